s_div_share_arb: RTL and testbench

- Shares one sequential radix-2 divider among N_REQ streaming PEs that issue DIV/REM-class operations, so each PE does not need its own divider.
- Grants requesters in round-robin order and runs one division at a time. Returns quotient and remainder to the granted requester over a valid/ready response channel.
- Sits in the PEA next to the division-capable PEs. Honours the array-wide stall (pea_ready_i) and the end-of-kernel flush (mage_done_i).

---
 rtl/pea_pkg.sv | 29 ++
 rtl/s_seq_divider.sv | 76 +++++++
 rtl/s_div_share_arb.sv | 131 +++++++++++++
 tb/tb_s_div_share_arb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pea_pkg.sv
// Shared PEA types for the divider-sharing arbiter: operation codes, FSM states
// and the default requester count.
package pea_pkg;

  localparam int unsigned N_DIV_REQ = 4;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_FIX,
    ARB_RESP
  } div_arb_state_t;

  function automatic logic op_is_signed(input div_op_t op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/s_seq_divider.sv
// Sequential radix-2 restoring divider: one iteration per enabled cycle on operand
// magnitudes, with the sign and divide-by-zero fix applied combinationally at the output.
module s_seq_divider #(
  parameter int unsigned N_BITS = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              enable_i,
  input  logic              signed_i,
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  output logic [N_BITS-1:0] quotient_c,
  output logic [N_BITS-1:0] remainder_c,
  output logic              done_c
);

  localparam int unsigned CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);

  logic [N_BITS-1:0] rem_q, quo_q, dvs_q, a_q, b_q;
  logic              sgn_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [N_BITS-1:0] a_mag, b_mag;
  logic [N_BITS:0]   shifted, trial;
  logic              fit, neg_q, neg_r;

  // Operand magnitudes at start and the trial subtraction of the current step
  always_comb begin
    a_mag   = (signed_i && a_i[N_BITS-1]) ? -a_i : a_i;
    b_mag   = (signed_i && b_i[N_BITS-1]) ? -b_i : b_i;
    shifted = {rem_q, quo_q[N_BITS-1]};
    trial   = shifted - {1'b0, dvs_q};
    fit     = ~trial[N_BITS];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      rem_q <= '0;
      quo_q <= a_mag;
      dvs_q <= b_mag;
      a_q   <= a_i;
      b_q   <= b_i;
      sgn_q <= signed_i;
      cnt_q <= '0;
    end else if (enable_i) begin
      rem_q <= fit ? trial[N_BITS-1:0] : shifted[N_BITS-1:0];
      quo_q <= {quo_q[N_BITS-2:0], fit};
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // MIN / -1 falls out naturally: |MIN| / 1 = MIN with matching signs, remainder 0
  always_comb begin
    done_c = enable_i && (cnt_q == CNT_LAST);
    neg_q  = sgn_q && (a_q[N_BITS-1] ^ b_q[N_BITS-1]);
    neg_r  = sgn_q && a_q[N_BITS-1];
    if (b_q == '0) begin
      quotient_c  = '1;
      remainder_c = a_q;
    end else begin
      quotient_c  = neg_q ? -quo_q : quo_q;
      remainder_c = neg_r ? -rem_q : rem_q;
    end
  end

endmodule

// File: rtl/s_div_share_arb.sv
// Round-robin arbiter sharing one sequential divider among N_REQ PEs; returns
// quotient/remainder over a valid/ready response channel, honours stall and flush.
module s_div_share_arb
  import pea_pkg::*;
#(
  parameter int unsigned N_REQ  = N_DIV_REQ,
  parameter int unsigned N_BITS = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      mage_done_i,
  input  logic                      pea_ready_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [2*N_REQ-1:0]        req_op_i,
  input  logic [N_REQ*N_BITS-1:0]   req_a_i,
  input  logic [N_REQ*N_BITS-1:0]   req_b_i,
  output logic                      resp_valid_o,
  input  logic [N_REQ-1:0]          resp_ready_i,
  output logic [$clog2(N_REQ)-1:0]  resp_id_o,
  output logic [N_BITS-1:0]         resp_res_o,
  output logic [N_BITS-1:0]         resp_alt_o,
  output logic                      busy_o
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  div_arb_state_t    state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, gnt_id_q, resp_id_q, cand_id;
  div_op_t           op_q, cand_op;
  logic              resp_valid_q, busy_q, cand_found;
  logic [N_BITS-1:0] resp_res_q, resp_alt_q, cand_a, cand_b, div_q, div_r;
  logic              accept, handshake, div_enable, div_done;

  // Round-robin candidate: first valid requester after the last served one
  always_comb begin : cand_pick
    int idx;
    cand_found = 1'b0;
    cand_id    = '0;
    idx        = 0;
    for (int i = 1; i <= int'(N_REQ); i++) begin
      idx = int'(last_grant_q) + i;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      if (!cand_found && req_valid_i[ID_W'(idx)]) begin
        cand_found = 1'b1;
        cand_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    cand_op     = div_op_t'(req_op_i[cand_id*2 +: 2]);
    cand_a      = req_a_i[cand_id*N_BITS +: N_BITS];
    cand_b      = req_b_i[cand_id*N_BITS +: N_BITS];
    accept      = (state_q == ARB_IDLE) && pea_ready_i && !mage_done_i && cand_found;
    handshake   = (state_q == ARB_RESP) && pea_ready_i && !mage_done_i && resp_ready_i[resp_id_q];
    div_enable  = (state_q == ARB_BUSY) && pea_ready_i && !mage_done_i;
    req_ready_o = accept ? (N_REQ'(1) << cand_id) : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mage_done_i) begin
      state_d = ARB_IDLE;
    end else begin
      case (state_q)
        ARB_IDLE: if (accept)      state_d = ARB_BUSY;
        ARB_BUSY: if (div_done)    state_d = ARB_FIX;
        ARB_FIX:  if (pea_ready_i) state_d = ARB_RESP;
        ARB_RESP: if (handshake)   state_d = ARB_IDLE;
        default:                   state_d = ARB_IDLE;
      endcase
    end
  end

  // Request capture, response registers and round-robin pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= ID_W'(N_REQ - 1);
      gnt_id_q     <= '0;
      op_q         <= DIV_OP_DIV;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      resp_id_q    <= '0;
      resp_res_q   <= '0;
      resp_alt_q   <= '0;
    end else begin
      busy_q       <= (state_d != ARB_IDLE);
      resp_valid_q <= (state_d == ARB_RESP);
      if (mage_done_i || handshake) begin
        resp_id_q  <= '0;
        resp_res_q <= '0;
        resp_alt_q <= '0;
      end else if ((state_q == ARB_FIX) && pea_ready_i) begin
        resp_id_q  <= gnt_id_q;
        resp_res_q <= op_is_rem(op_q) ? div_r : div_q;
        resp_alt_q <= op_is_rem(op_q) ? div_q : div_r;
      end
      if (handshake) last_grant_q <= resp_id_q;
      if (accept) begin
        op_q     <= cand_op;
        gnt_id_q <= cand_id;
      end
    end
  end

  s_seq_divider #(.N_BITS(N_BITS)) u_div (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (accept),
    .enable_i    (div_enable),
    .signed_i    (op_is_signed(cand_op)),
    .a_i         (cand_a),
    .b_i         (cand_b),
    .quotient_c  (div_q),
    .remainder_c (div_r),
    .done_c      (div_done)
  );

  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign resp_res_o   = resp_res_q;
  assign resp_alt_o   = resp_alt_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_s_div_share_arb.sv
// Self-checking bench for s_div_share_arb: directed cases plus randomized traffic
// checked against a scoreboard fed by a plain-arithmetic divide model.
module tb_s_div_share_arb;

  localparam int N_REQ  = 4;
  localparam int N_BITS = 32;

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] a, b, res, alt;
  } op_t;

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b1;
  logic                     mage_done_i = 1'b0;
  logic                     pea_ready_i = 1'b1;
  logic [N_REQ-1:0]         req_valid_i = '0;
  logic [N_REQ-1:0]         req_ready_o;
  logic [2*N_REQ-1:0]       req_op_i = '0;
  logic [N_REQ*N_BITS-1:0]  req_a_i = '0;
  logic [N_REQ*N_BITS-1:0]  req_b_i = '0;
  logic                     resp_valid_o;
  logic [N_REQ-1:0]         resp_ready_i = '1;
  logic [1:0]               resp_id_o;
  logic [N_BITS-1:0]        resp_res_o, resp_alt_o;
  logic                     busy_o;

  s_div_share_arb #(.N_REQ(N_REQ), .N_BITS(N_BITS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mage_done_i(mage_done_i), .pea_ready_i(pea_ready_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o), .resp_res_o(resp_res_o),
    .resp_alt_o(resp_alt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference divide: truncating signed division, remainder follows dividend
  function automatic void ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic [31:0] alt);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1; r = a;
    end else if (op[0] == 1'b0) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a; r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
    res = op[1] ? r : q;
    alt = op[1] ? q : r;
  endfunction

  function automatic logic [N_REQ-1:0] exp_ready(input logic [N_REQ-1:0] v, input int last);
    for (int i = 1; i <= N_REQ; i++) begin
      if (v[(last + i) % N_REQ]) return N_REQ'(1) << ((last + i) % N_REQ);
    end
    return '0;
  endfunction

  op_t  drv_q[N_REQ][$];
  op_t  sb[$];
  int   grant_log[$];
  logic [N_REQ-1:0] acc_vec = '0;
  int   cyc = 0, acc_edge = 0, stalls = 0, model_last = N_REQ - 1;
  bit   seen = 0, rand_mode = 0;
  logic pea_ready_man = 1'b1;
  logic [N_REQ-1:0] resp_ready_man = '1;
  logic [1:0]  held_id;
  logic [31:0] held_res, held_alt;

  always @(posedge clk_i) cyc++;

  // Requester driver: hold head op until accepted, then advance
  always @(posedge clk_i) begin
    #1;
    for (int r = 0; r < N_REQ; r++) begin
      if (acc_vec[r] && drv_q[r].size() != 0) drv_q[r].delete(0);
      if (drv_q[r].size() != 0) begin
        req_valid_i[r]           = 1'b1;
        req_op_i[r*2 +: 2]       = drv_q[r][0].op;
        req_a_i[r*N_BITS +: 32]  = drv_q[r][0].a;
        req_b_i[r*N_BITS +: 32]  = drv_q[r][0].b;
      end else begin
        req_valid_i[r] = 1'b0;
      end
    end
    acc_vec = '0;
    if (rand_mode) begin
      pea_ready_i  = ($urandom_range(9) != 0);
      resp_ready_i = N_REQ'($urandom);
    end else begin
      pea_ready_i  = pea_ready_man;
      resp_ready_i = resp_ready_man;
    end
  end

  // Monitor: grant order, latency, results and response hold
  always @(negedge clk_i) begin
    if (rst_i) begin
      sb.delete();
      model_last = N_REQ - 1;
      seen = 0; stalls = 0; acc_vec = '0;
    end else if (sb.size() != 0) begin
      check("no_accept_busy", req_ready_o, 0);
      check("busy", busy_o, 1);
      if (resp_valid_o) begin
        if (!seen) begin
          seen = 1;
          check("latency", cyc - acc_edge, N_BITS + 1 + stalls);
          check("resp_id", resp_id_o, sb[0].id);
          check("resp_res", resp_res_o, sb[0].res);
          check("resp_alt", resp_alt_o, sb[0].alt);
          held_id = resp_id_o; held_res = resp_res_o; held_alt = resp_alt_o;
        end else begin
          check("hold_id", resp_id_o, held_id);
          check("hold_val", {resp_res_o, resp_alt_o}, {held_res, held_alt});
        end
      end else if (!seen && !pea_ready_i) begin
        stalls++;
      end
      if (mage_done_i) begin
        sb.delete(); seen = 0; stalls = 0;
      end else if (seen && pea_ready_i && resp_ready_i[sb[0].id]) begin
        model_last = sb[0].id;
        sb.delete(0); seen = 0; stalls = 0;
      end
    end else begin
      logic [N_REQ-1:0] exp;
      exp = (pea_ready_i && !mage_done_i) ? exp_ready(req_valid_i, model_last) : '0;
      check("spurious_resp", resp_valid_o, 0);
      check("busy_idle", busy_o, 0);
      check("req_ready", req_ready_o, exp);
      if (exp != 0 && req_ready_o == exp) begin
        for (int r = 0; r < N_REQ; r++) begin
          if (exp[r]) begin
            sb.push_back(drv_q[r][0]);
            grant_log.push_back(r);
          end
        end
        acc_edge = cyc + 1;
        acc_vec  = exp;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic push_op(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic [31:0] alt);
    op_t t;
    t.id = r; t.op = op; t.a = a; t.b = b; t.res = res; t.alt = alt;
    drv_q[r].push_back(t);
  endtask

  task automatic push_model(input int r, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res, alt;
    ref_div(op, a, b, res, alt);
    push_op(r, op, a, b, res, alt);
  endtask

  task automatic push_rand(input int r);
    logic [31:0] a, b;
    case ($urandom_range(7))
      0: begin a = $urandom; b = 32'd0; end
      1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      2: begin a = $urandom_range(1000); b = $urandom_range(20, 1); end
      3: begin a = -$urandom_range(1000); b = $urandom_range(20, 1); end
      default: begin a = $urandom; b = $urandom >> $urandom_range(31); end
    endcase
    push_model(r, 2'($urandom_range(3)), a, b);
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() != 0) break;
      tick();
    end
    check("accept_seen", logic'(sb.size() != 0), 1);
  endtask

  task automatic drain(input int limit);
    bit done = 0;
    for (int i = 0; i < limit; i++) begin
      done = (sb.size() == 0) && !busy_o && !resp_valid_o;
      for (int r = 0; r < N_REQ; r++) if (drv_q[r].size() != 0) done = 0;
      if (done) break;
      tick();
    end
    check("drain", done, 1);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_busy", busy_o, 0);
    check("rst_valid", resp_valid_o, 0);
    check("rst_id", resp_id_o, 0);
    check("rst_res", {resp_res_o, resp_alt_o}, 0);
    check("rst_ready", req_ready_o, 0);
    rst_i = 1'b0;
    tick();

    // All requesters valid: grants rotate 0,1,2,3,0,1,2,3
    grant_log.delete();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < N_REQ; r++) push_model(r, 2'b01, 32'(1000 + 17 * r + k), 32'(r + k + 1));
    drain(1000);
    check("rr_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) check("rr_order", grant_log[i], i % N_REQ);

    push_op(0, 2'b01, 32'd100, 32'd7, 32'd14, 32'd2);                         drain(200);
    push_op(2, 2'b00, -32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);          drain(200);
    push_op(2, 2'b10, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);          drain(200);
    push_op(1, 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);                    drain(200);
    push_op(1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);   drain(200);
    push_op(3, 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);                    drain(200);

    // Five-cycle stall in BUSY stretches latency to 38
    push_op(1, 2'b01, 32'd1000, 32'd9, 32'd111, 32'd1);
    wait_accept();
    repeat (8) tick();
    pea_ready_man = 1'b0;
    repeat (5) tick();
    pea_ready_man = 1'b1;
    drain(200);

    // Consumer not ready (other ready bits set) holds the response; no new accept
    resp_ready_man = 4'b1011;
    push_op(2, 2'b01, 32'd50, 32'd5, 32'd10, 32'd0);
    push_op(3, 2'b01, 32'd9, 32'd4, 32'd2, 32'd1);
    for (int i = 0; i < 100 && !resp_valid_o; i++) tick();
    repeat (3) tick();
    check("hold_valid", resp_valid_o, 1);
    check("hold_owner", resp_id_o, 2);
    check("hold_no_accept", req_ready_o, 0);
    resp_ready_man = '1;
    drain(300);

    // Flush mid-BUSY via mage_done, then a fresh request
    push_op(1, 2'b01, 32'd77, 32'd7, 32'd11, 32'd0);
    wait_accept();
    repeat (9) tick();
    mage_done_i = 1'b1;
    tick();
    mage_done_i = 1'b0;
    check("flush_busy", busy_o, 0);
    check("flush_valid", resp_valid_o, 0);
    repeat (40) tick();
    push_op(0, 2'b01, 32'd100, 32'd7, 32'd14, 32'd2);
    drain(200);

    // Reset mid-BUSY, then a fresh request
    push_op(3, 2'b00, 32'd123, 32'd5, 32'd24, 32'd3);
    wait_accept();
    repeat (9) tick();
    rst_i = 1'b1;
    tick();
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_valid", resp_valid_o, 0);
    rst_i = 1'b0;
    tick();
    push_op(0, 2'b00, -32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    drain(200);

    // Randomized traffic with random stalls and consumer backpressure
    rand_mode = 1;
    for (int i = 0; i < 40; i++) push_rand($urandom_range(N_REQ - 1));
    drain(8000);
    rand_mode = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
